// File: rtl/muldiv_pkg.sv
// Shared op-codes, FSM state type and default datapath width for the
// multiply/divide controller.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: right-shifting shift-add for
// multiply, restoring subtract-shift for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, b};
    shifted = {hi, lo[WIDTH-1]};
    // remainder stays below b, so a successful subtract always fits WIDTH bits
    diff    = shifted[WIDTH-1:0] - b;
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (is_div) begin
      if (shifted >= {1'b0, b}) begin
        nxt_hi = diff;
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], lo[WIDTH-1:1]};
      end else begin
        nxt_hi = {1'b0, hi[WIDTH-1:1]};
        nxt_lo = {hi[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide controller: FSM, step counter, handshake and sign fix.
// Define MULDIV_SIGNED_EN to make ops 10/11 signed two's-complement.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_dbz,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q, sgn_q, sa_q, sb_q, dbz_q;

  logic             op_signed, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_neg;

`ifdef MULDIV_SIGNED_EN
  assign op_signed = req_op[1];
`else
  logic unused_op_hi;
  assign op_signed    = 1'b0;
  assign unused_op_hi = req_op[1];
`endif

  always_comb begin
    op_div   = (req_op == OP_DIVU) || (req_op == OP_DIV);
    a_mag    = (op_signed && req_a[WIDTH-1]) ? -req_a : req_a;
    b_mag    = (op_signed && req_b[WIDTH-1]) ? -req_b : req_b;
    prod_neg = -{hi_q, lo_q};
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // CALC spends WIDTH cycles stepping and one more observing cnt==0,
  // which yields WIDTH+1 unsigned latency; divide-by-zero leaves after one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      sgn_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state <= ST_CALC;
            cnt   <= CW'(WIDTH);
            div_q <= op_div;
            sgn_q <= op_signed;
            sa_q  <= op_signed & req_a[WIDTH-1];
            sb_q  <= op_signed & req_b[WIDTH-1];
            b_q   <= b_mag;
            if (op_div && (req_b == '0)) begin
              dbz_q <= 1'b1;
              hi_q  <= req_a;
              lo_q  <= '1;
            end else begin
              dbz_q <= 1'b0;
              hi_q  <= '0;
              lo_q  <= a_mag;
            end
          end
        end
        ST_CALC: begin
          if (dbz_q) begin
            state <= ST_DONE;
          end else if (cnt == '0) begin
            state <= sgn_q ? ST_FIX : ST_DONE;
          end else begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            cnt  <= cnt - CW'(1);
          end
        end
        ST_FIX: begin
          state <= ST_DONE;
          if (!div_q) begin
            if (sa_q ^ sb_q) {hi_q, lo_q} <= prod_neg;
          end else begin
            if (sa_q ^ sb_q) lo_q <= -lo_q;
            if (sa_q) hi_q <= -hi_q;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_dbz   = dbz_q;

endmodule
